zports_io: RTL and testbench
============================

Name: zports_io

Overview:
- Upstream neighbour of the ZX-bus IORQ/IORQGE stage.
- Decodes Z80 I/O addresses and drives the combinational `porthit` that stage consumes to gate external IORQ.
- Synchronises Z80 IORQ/RD/WR/M1 into the fclk domain and produces single-cycle read/write strobes.
- Holds the internal write ports (#FE border, #7FFD paging with lock, #EFF7 config) and supplies read-back data.

Parameters:
- EFF7_EN, 1, 1 = port #EFF7 decoded and writable; 0 = never hits, peff7 held at reset value.
- BORDER_W, 3, width of border register (1..3).

Ports:
- fclk  in  1  system clock, sole clock.
- rst  in  1  reset, asynchronous, active-high.
- a  in  16  Z80 address bus.
- din  in  8  Z80 data bus (write data).
- iorq_n  in  1  Z80 IORQ, async to fclk.
- rd_n  in  1  Z80 RD, async.
- wr_n  in  1  Z80 WR, async.
- m1_n  in  1  Z80 M1, async.
- porthit  out  1  combinational: access addresses an internal port.
- dout  out  8  read-back data, combinational from a and registers.
- dout_ena  out  1  combinational: drive dout onto Z80 bus.
- port_wr_stb  out  1  one-cycle strobe, internal port write completed.
- port_rd_stb  out  1  one-cycle strobe, internal port read started.
- port_sel  out  2  registered id of strobed port: 0 = FE, 1 = 7FFD, 2 = EFF7, 3 = none.
- border  out  BORDER_W  port #FE bits [BORDER_W-1:0].
- page7ffd  out  8  port #7FFD register.
- peff7  out  8  port #EFF7 register.

Behaviour:

Decode (combinational, asynchronous to fclk):
- hit_fe = (a[0]==0).
- hit_7ffd = (a[15:14]==2'b01) & (a[7:0]==8'hFD).
- hit_eff7 = EFF7_EN & (a==16'hEFF7).
- porthit = m1_n & (hit_7ffd | hit_eff7 | (hit_fe & ~wr_n)).
  - #FE is write-only here; FE reads belong to the keyboard path.
- dout: page7ffd when hit_7ffd, peff7 when hit_eff7, else 8'hFF.
- dout_ena = ~iorq_n & ~rd_n & m1_n & (hit_7ffd | hit_eff7).

Synchronisation:
- qwr = ~(iorq_n | wr_n | ~m1_n); qrd = ~(iorq_n | rd_n | ~m1_n).
- Each passes through a 3-flop chain s1 -> s2 -> s3.
- Rising edge is detected as s2 & ~s3.
- Latency: strobe is high for exactly one fclk cycle, registered. It rises on the 3rd rising fclk edge after the first edge that samples the qualifier active (s1 at edge 1, s2 at edge 2, strobe at edge 3).
- Qualifiers shorter than one fclk period may be missed; this is acceptable because Z80 I/O cycles at fclk >= 4x CPU clock are always >= 2 fclk.
- On the strobe edge:
  - a and din are sampled. They have been stable for >= 2 fclk while the qualifier is active.
  - port_sel <= decoded id, priority 7FFD > EFF7 > FE > none.
  - port_wr_stb/port_rd_stb are asserted only if port_sel != 3 (hit at capture).

Register writes (on the port_wr_stb edge):
- FE: border <= din[BORDER_W-1:0].
- 7FFD: page7ffd <= din, only if page7ffd[5]==0. When locked, the write is ignored but port_wr_stb still fires.
- EFF7: peff7 <= din.

Reset (async assert, sync release):
- border = 0, page7ffd = 0, peff7 = 0, port_sel = 3, strobes = 0.
- Sync chains reset to 1 (active). An access already in progress at reset release produces no strobe; the next full access produces exactly one.

Boundary cases:
- Simultaneous qrd and qwr cannot occur on a Z80. If forced, write wins and no read strobe is issued that cycle.
- Back-to-back accesses separated by >= 2 fclk of inactive qualifier each produce one strobe.
- A held-low qualifier produces one strobe only, with no re-trigger.
- M1 low (IM2 acknowledge) never hits, strobes, or drives dout.

Test Plan:
- Reset asserted mid-write, released while wr still low -> no port_wr_stb; border, page7ffd, peff7 = 0; port_sel = 3.
- OUT (#7FFD),#17 held 4 fclk -> porthit=1 immediately; port_wr_stb 1 cycle at edge 3; port_sel=1; page7ffd=#17.
- OUT #7FFD,#20 then OUT #7FFD,#05 -> page7ffd=#20 after both writes; both strobes fire (lock behaviour).
- OUT #EFF7,#A5 then IN #EFF7 -> peff7=#A5; dout=#A5 and dout_ena=1 during read; port_rd_stb once, port_sel=2. Repeat with EFF7_EN=0 -> porthit=0, no strobes, peff7=0.
- OUT #FE,#FF (BORDER_W=3) -> border=3'b111. IN #FE -> porthit=0, dout_ena=0, no rd strobe.
- IORQ+M1 low with a=#7FFD -> porthit=0, dout_ena=0, no strobes; 1-fclk-wide qualifier pulse -> at most one strobe.

Source files
------------

// File: rtl/zports_io_if.sv
// Z80 I/O-side bus of the internal port block: address/data/control in,
// decode hit and read-back data out.
interface zports_io_if;
   logic [15:0] a;
   logic [7:0]  din;
   logic        iorq_n;
   logic        rd_n;
   logic        wr_n;
   logic        m1_n;
   logic        porthit;
   logic [7:0]  dout;
   logic        dout_ena;

   modport master (
      output a, din, iorq_n, rd_n, wr_n, m1_n,
      input  porthit, dout, dout_ena
   );

   modport slave (
      input  a, din, iorq_n, rd_n, wr_n, m1_n,
      output porthit, dout, dout_ena
   );
endinterface

// File: rtl/zports_io.sv
// Z80 internal I/O ports (#FE border, #7FFD paging with lock, #EFF7 config):
// async address decode plus fclk-synchronised read/write strobes.
module zports_io #(
   parameter bit EFF7_EN  = 1'b1,
   parameter int BORDER_W = 3
) (
   input  logic                fclk,
   input  logic                rst,
   zports_io_if.slave          bus,
   output logic                port_wr_stb,
   output logic                port_rd_stb,
   output logic [1:0]          port_sel,
   output logic [BORDER_W-1:0] border,
   output logic [7:0]          page7ffd,
   output logic [7:0]          peff7
);
   localparam logic [1:0] SEL_FE   = 2'd0;
   localparam logic [1:0] SEL_7FFD = 2'd1;
   localparam logic [1:0] SEL_EFF7 = 2'd2;
   localparam logic [1:0] SEL_NONE = 2'd3;

   logic       hit_fe;
   logic       hit_7ffd;
   logic       hit_eff7;
   logic       qwr;
   logic       qrd;
   logic [2:0] swr;
   logic [2:0] srd;
   logic       wr_edge;
   logic       rd_edge;
   logic [1:0] wr_id;
   logic [1:0] rd_id;

   assign hit_fe   = ~bus.a[0];
   assign hit_7ffd = (bus.a[15:14] == 2'b01) && (bus.a[7:0] == 8'hFD);
   assign hit_eff7 = EFF7_EN && (bus.a == 16'hEFF7);

   // #FE is write-only here; FE reads belong to the keyboard path.
   assign bus.porthit  = bus.m1_n & (hit_7ffd | hit_eff7 | (hit_fe & ~bus.wr_n));
   assign bus.dout     = hit_7ffd ? page7ffd : (hit_eff7 ? peff7 : 8'hFF);
   assign bus.dout_ena = ~bus.iorq_n & ~bus.rd_n & bus.m1_n & (hit_7ffd | hit_eff7);

   assign qwr = ~(bus.iorq_n | bus.wr_n | ~bus.m1_n);
   assign qrd = ~(bus.iorq_n | bus.rd_n | ~bus.m1_n);

   assign wr_edge = swr[1] & ~swr[2];
   assign rd_edge = srd[1] & ~srd[2];

   assign wr_id = hit_7ffd ? SEL_7FFD : (hit_eff7 ? SEL_EFF7 : (hit_fe ? SEL_FE : SEL_NONE));
   assign rd_id = hit_7ffd ? SEL_7FFD : (hit_eff7 ? SEL_EFF7 : SEL_NONE);

   // Chains reset to "active" so an access straddling reset release gives no edge.
   always_ff @(posedge fclk or posedge rst) begin
      if (rst) begin
         swr <= 3'b111;
         srd <= 3'b111;
      end else begin
         swr <= {swr[1:0], qwr};
         srd <= {srd[1:0], qrd};
      end
   end

   always_ff @(posedge fclk or posedge rst) begin
      if (rst) begin
         port_wr_stb <= 1'b0;
         port_rd_stb <= 1'b0;
         port_sel    <= SEL_NONE;
         border      <= '0;
         page7ffd    <= 8'h00;
         peff7       <= 8'h00;
      end else begin
         port_wr_stb <= 1'b0;
         port_rd_stb <= 1'b0;
         if (wr_edge) begin
            port_sel    <= wr_id;
            port_wr_stb <= (wr_id != SEL_NONE);
            case (wr_id)
               SEL_FE:   border <= bus.din[BORDER_W-1:0];
               SEL_7FFD: if (!page7ffd[5]) page7ffd <= bus.din;
               SEL_EFF7: peff7 <= bus.din;
               default:  ;
            endcase
         end else if (rd_edge) begin
            port_sel    <= rd_id;
            port_rd_stb <= (rd_id != SEL_NONE);
         end
      end
   end
endmodule

// File: tb/tb_zports_io.sv
// Bench for zports_io: two instances (EFF7 decoded / not decoded) driven by the
// same Z80 bus stimulus and compared against a behavioural port model.
module tb_zports_io;
   logic        fclk;
   logic        rst;
   logic [15:0] a;
   logic [7:0]  din;
   logic        iorq_n, rd_n, wr_n, m1_n;

   logic        wstb [2];
   logic        rstb [2];
   logic [1:0]  psel [2];
   logic [2:0]  bd   [2];
   logic [7:0]  pg   [2];
   logic [7:0]  pe   [2];
   logic        ph   [2];
   logic [7:0]  dq   [2];
   logic        de   [2];

   int wcnt [2];
   int rcnt [2];
   int lsel [2];

   int checks   = 0;
   int failures = 0;

   logic [2:0] mb [2];
   logic [7:0] mp [2];
   logic [7:0] me [2];

   zports_io_if z0 ();
   zports_io_if z1 ();

   assign z0.a = a;      assign z1.a = a;
   assign z0.din = din;  assign z1.din = din;
   assign z0.iorq_n = iorq_n; assign z1.iorq_n = iorq_n;
   assign z0.rd_n = rd_n; assign z1.rd_n = rd_n;
   assign z0.wr_n = wr_n; assign z1.wr_n = wr_n;
   assign z0.m1_n = m1_n; assign z1.m1_n = m1_n;
   assign ph[0] = z0.porthit;  assign ph[1] = z1.porthit;
   assign dq[0] = z0.dout;     assign dq[1] = z1.dout;
   assign de[0] = z0.dout_ena; assign de[1] = z1.dout_ena;

   zports_io #(.EFF7_EN(1'b0), .BORDER_W(3)) dut0 (
      .fclk(fclk), .rst(rst), .bus(z0),
      .port_wr_stb(wstb[0]), .port_rd_stb(rstb[0]), .port_sel(psel[0]),
      .border(bd[0]), .page7ffd(pg[0]), .peff7(pe[0])
   );

   zports_io #(.EFF7_EN(1'b1), .BORDER_W(3)) dut1 (
      .fclk(fclk), .rst(rst), .bus(z1),
      .port_wr_stb(wstb[1]), .port_rd_stb(rstb[1]), .port_sel(psel[1]),
      .border(bd[1]), .page7ffd(pg[1]), .peff7(pe[1])
   );

   initial begin
      fclk = 1'b0;
      forever #5 fclk = ~fclk;
   end

   always @(negedge fclk) begin
      for (int i = 0; i < 2; i++) begin
         if (wstb[i]) begin wcnt[i]++; lsel[i] = int'(psel[i]); end
         if (rstb[i]) begin rcnt[i]++; lsel[i] = int'(psel[i]); end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mb[i] = 3'd0; mp[i] = 8'h00; me[i] = 8'h00;
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_border%0d", tag, i), 32'(bd[i]), 32'(mb[i]));
         chk($sformatf("%s_page%0d", tag, i), 32'(pg[i]), 32'(mp[i]));
         chk($sformatf("%s_peff7_%0d", tag, i), 32'(pe[i]), 32'(me[i]));
      end
   endtask

   // One Z80 I/O cycle; qualifier active for 'hold' fclk periods.
   // exact=0 means only "at most one strobe" is guaranteed (sub-2-cycle pulse).
   task automatic access(input string tag, input bit wr, input bit rdx, input logic [15:0] addr,
                         input logic [7:0] data, input bit m1_low, input int hold, input bit exact);
      int  w0 [2];
      int  r0 [2];
      bit  is7, ise, isfe, hit, ewr, erd;
      int  id;
      @(negedge fclk);
      for (int i = 0; i < 2; i++) begin w0[i] = wcnt[i]; r0[i] = rcnt[i]; end
      a = addr; din = data; m1_n = ~m1_low;
      iorq_n = 1'b0; wr_n = ~wr; rd_n = ~rdx;
      #1;
      for (int i = 0; i < 2; i++) begin
         is7  = (addr[15:14] == 2'b01) && (addr[7:0] == 8'hFD);
         ise  = (i == 1) && (addr == 16'hEFF7);
         isfe = (addr[0] == 1'b0);
         chk($sformatf("%s_porthit%0d", tag, i), 32'(ph[i]),
             32'(!m1_low && (is7 || ise || (isfe && wr))));
         chk($sformatf("%s_dout_ena%0d", tag, i), 32'(de[i]), 32'(!m1_low && rdx && (is7 || ise)));
         if (is7 || ise)
            chk($sformatf("%s_dout%0d", tag, i), 32'(dq[i]), 32'(is7 ? mp[i] : me[i]));
      end
      repeat (hold) @(negedge fclk);
      iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
      repeat (5) @(negedge fclk);
      #1;
      for (int i = 0; i < 2; i++) begin
         is7  = (addr[15:14] == 2'b01) && (addr[7:0] == 8'hFD);
         ise  = (i == 1) && (addr == 16'hEFF7);
         isfe = (addr[0] == 1'b0);
         if (m1_low) id = 3;
         else if (wr) id = is7 ? 1 : (ise ? 2 : (isfe ? 0 : 3));
         else if (rdx) id = is7 ? 1 : (ise ? 2 : 3);
         else id = 3;
         hit = (id != 3);
         ewr = hit && wr;
         erd = hit && rdx && !wr;
         if (exact) begin
            chk($sformatf("%s_wr_stb%0d", tag, i), 32'(wcnt[i] - w0[i]), 32'(ewr));
            chk($sformatf("%s_rd_stb%0d", tag, i), 32'(rcnt[i] - r0[i]), 32'(erd));
            if (hit) chk($sformatf("%s_sel%0d", tag, i), 32'(lsel[i]), 32'(id));
            if (ewr) begin
               if (id == 0) mb[i] = data[2:0];
               else if (id == 1) begin if (!mp[i][5]) mp[i] = data; end
               else if (id == 2) me[i] = data;
            end
         end else begin
            chk($sformatf("%s_atmost1_%0d", tag, i),
                32'((wcnt[i] - w0[i]) + (rcnt[i] - r0[i]) <= 1), 32'(1));
         end
      end
      check_regs(tag);
   endtask

   initial begin
      logic [15:0] ra;
      int          kind;
      bit          rwr;
      for (int i = 0; i < 2; i++) begin wcnt[i] = 0; rcnt[i] = 0; lsel[i] = 3; end
      model_reset();
      rst = 1'b1; a = 16'hFFFF; din = 8'h00;
      iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;

      // Write already in progress when reset releases.
      repeat (2) @(negedge fclk);
      a = 16'h7FFD; din = 8'h17; iorq_n = 1'b0; wr_n = 1'b0;
      repeat (2) @(negedge fclk);
      rst = 1'b0;
      repeat (4) @(negedge fclk);
      iorq_n = 1'b1; wr_n = 1'b1;
      repeat (5) @(negedge fclk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_wr_stb%0d", i), 32'(wcnt[i]), 32'(0));
         chk($sformatf("rst_sel%0d", i), 32'(psel[i]), 32'(3));
      end
      check_regs("rst");

      access("out7ffd_17", 1, 0, 16'h7FFD, 8'h17, 0, 4, 1);
      access("out7ffd_20", 1, 0, 16'h7FFD, 8'h20, 0, 3, 1);
      access("out7ffd_05", 1, 0, 16'h7FFD, 8'h05, 0, 3, 1);
      access("in7ffd",     0, 1, 16'h7FFD, 8'h00, 0, 3, 1);
      access("outeff7",    1, 0, 16'hEFF7, 8'hA5, 0, 3, 1);
      access("ineff7",     0, 1, 16'hEFF7, 8'h00, 0, 3, 1);
      access("outfe",      1, 0, 16'h00FE, 8'hFF, 0, 3, 1);
      access("infe",       0, 1, 16'h00FE, 8'h00, 0, 3, 1);
      access("m1_rd",      0, 1, 16'h7FFD, 8'h00, 1, 3, 1);
      access("m1_wr",      1, 0, 16'h7FFD, 8'h00, 1, 3, 1);
      access("held",       1, 0, 16'h12FE, 8'h02, 0, 12, 1);
      access("both",       1, 1, 16'hEFF7, 8'h3C, 0, 3, 1);
      access("pulse",      0, 1, 16'h7FFD, 8'h00, 0, 1, 0);

      // Second reset, then randomised traffic.
      @(negedge fclk);
      rst = 1'b1;
      @(negedge fclk);
      rst = 1'b0;
      model_reset();
      @(negedge fclk);
      #1;
      check_regs("rst2");
      for (int n = 0; n < 60; n++) begin
         kind = int'($urandom_range(0, 3));
         ra   = 16'($urandom);
         case (kind)
            0: ra = {2'b01, ra[5:0], 8'hFD};
            1: ra = 16'hEFF7;
            2: ra[0] = 1'b0;
            default: ra[0] = 1'b1;
         endcase
         rwr = 1'($urandom);
         access($sformatf("rnd%0d", n), rwr, ~rwr, ra, 8'($urandom),
                ($urandom_range(0, 7) == 0), int'($urandom_range(2, 6)), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
